// File: rtl/gmii_frame_gen.sv
// gmii_frame_gen
//   Programmable GMII transmit source. It emits bursts of frames, each made of
//   PREAMBLE_LEN bytes of 0x55, one 0xD5 SFD byte and frame_len payload bytes.
//   Every frame is followed by IPG_LEN idle cycles. The payload is either an
//   incrementing count, a constant fill byte or PRBS8. A burst can be aborted
//   at a frame boundary.
//
//   Optional feature macro: GMII_FRAME_GEN_ERR_INJECT_EN
//     When defined, one payload byte per frame can be replaced by an error
//     symbol (TXD=0x0F, TX_ER=1). When undefined, TX_ER stays 0 and
//     err_en/err_idx are unused.
//
// Ports
//   GTX_CLK       transmit clock (the only clock)
//   mr_main_reset synchronous active-high reset
//   start         one-cycle burst request, honoured only when idle
//   abort         stop after the current frame and its IPG
//   frame_len     payload bytes per frame (0 is treated as 1), latched at start
//   num_frames    frames per burst, latched at start
//   payload_mode  0 incrementing, 1 fill_byte, 2 PRBS8, 3 as 0
//   fill_byte     constant payload byte, latched at start
//   err_en        error injection enable (macro build only)
//   err_idx       payload byte index to corrupt (macro build only)
//   TXD/TX_EN/TX_ER  registered GMII transmit outputs
//   busy          burst in progress
//   done          one-cycle pulse at burst end
//   frame_cnt     frames fully sent in the current or last burst
module gmii_frame_gen #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_LEN      = 12,
    parameter int LEN_W        = 11,
    parameter int CNT_W        = 16
) (
    input  logic             GTX_CLK,
    input  logic             mr_main_reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [1:0]       payload_mode,
    input  logic [7:0]       fill_byte,
    input  logic             err_en,
    input  logic [LEN_W-1:0] err_idx,
    output logic [7:0]       TXD,
    output logic             TX_EN,
    output logic             TX_ER,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);
    // Phase counter must hold preamble, payload and IPG positions.
    localparam int IPG_W = $clog2(IPG_LEN + 1);
    localparam int PH_W0 = (LEN_W > IPG_W) ? LEN_W : IPG_W;
    localparam int PH_W  = (PH_W0 > 4) ? PH_W0 : 4;
    localparam logic [PH_W-1:0] PRE_LAST = PH_W'(PREAMBLE_LEN - 1);
    localparam logic [PH_W-1:0] IPG_LAST = PH_W'(IPG_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_PAY, S_IPG, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [PH_W-1:0]  ph;
    logic [CNT_W-1:0] sent;
    logic             abort_pend;
    logic [7:0]       lfsr;
    logic [LEN_W-1:0] len_l;
    logic [CNT_W-1:0] num_l;
    logic [1:0]       mode_l;
    logic [7:0]       fill_l;
    logic [PH_W-1:0]  pay_last;
    logic             active, take_start, last_pay, err_hit;
    logic [7:0]       pay_byte, txd_d;
    logic             en_d, er_d;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign pay_last   = PH_W'(len_l) - PH_W'(1);
    assign active     = (state == S_PRE) || (state == S_SFD) ||
                        (state == S_PAY) || (state == S_IPG);
    assign take_start = (state == S_IDLE) && start;
    assign last_pay   = (state == S_PAY) && (ph == pay_last);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (num_frames == '0) ? S_DONE : S_PRE;
            S_PRE:  if (ph == PRE_LAST) state_nxt = S_SFD;
            S_SFD:  state_nxt = S_PAY;
            S_PAY:  if (ph == pay_last) state_nxt = S_IPG;
            // An abort arriving in the final IPG cycle still counts.
            S_IPG:  if (ph == IPG_LAST)
                        state_nxt = ((sent < num_l) && !abort_pend && !abort) ? S_PRE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state      <= S_IDLE;
            ph         <= '0;
            sent       <= '0;
            abort_pend <= 1'b0;
            lfsr       <= 8'hFF;
        end else begin
            state <= state_nxt;
            ph    <= ((state_nxt != state) || (state == S_IDLE)) ? '0 : ph + PH_W'(1);
            if (take_start) begin
                sent       <= '0;
                abort_pend <= 1'b0;
            end else begin
                if (last_pay)        sent       <= sent + CNT_W'(1);
                if (active && abort) abort_pend <= 1'b1;
            end
            if (state == S_SFD)      lfsr <= 8'hFF;
            else if (state == S_PAY) lfsr <= lfsr_step(lfsr);
        end
    end

    // Burst parameters are captured once; later input changes are ignored.
    always_ff @(posedge GTX_CLK) begin
        if (take_start) begin
            len_l  <= (frame_len == '0) ? LEN_W'(1) : frame_len;
            num_l  <= num_frames;
            mode_l <= payload_mode;
            fill_l <= fill_byte;
        end
    end

`ifdef GMII_FRAME_GEN_ERR_INJECT_EN
    logic             err_en_l;
    logic [LEN_W-1:0] err_idx_l;

    always_ff @(posedge GTX_CLK) begin
        if (take_start) begin
            err_en_l  <= err_en;
            err_idx_l <= err_idx;
        end
    end

    assign err_hit = err_en_l && (err_idx_l < len_l) && (ph == PH_W'(err_idx_l));
`else
    logic unused_err;
    assign unused_err = ^{err_en, err_idx};
    assign err_hit    = 1'b0;
`endif

    // In PAY, sent is the 0-based index of the frame being transmitted.
    always_comb begin
        case (mode_l)
            2'd1:    pay_byte = fill_l;
            2'd2:    pay_byte = lfsr;
            default: pay_byte = 8'(sent) + 8'(ph);
        endcase
    end

    always_comb begin
        txd_d = 8'h00;
        en_d  = 1'b0;
        er_d  = 1'b0;
        case (state)
            S_PRE: begin
                txd_d = 8'h55;
                en_d  = 1'b1;
            end
            S_SFD: begin
                txd_d = 8'hD5;
                en_d  = 1'b1;
            end
            S_PAY: begin
                en_d = 1'b1;
                if (err_hit) begin
                    txd_d = 8'h0F;
                    er_d  = 1'b1;
                end else begin
                    txd_d = pay_byte;
                end
            end
            default: ;
        endcase
    end

    // Output register stage: outputs trail the state by one cycle.
    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            TXD       <= 8'h00;
            TX_EN     <= 1'b0;
            TX_ER     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            TXD       <= txd_d;
            TX_EN     <= en_d;
            TX_ER     <= er_d;
            busy      <= active;
            done      <= (state == S_DONE);
            frame_cnt <= sent;
        end
    end
endmodule

// File: doc/gmii_frame_gen.md
# gmii_frame_gen

Parametrised, synthesisable GMII frame generator driving the PCS transmit interface (TXD/TX_EN/TX_ER) on GTX_CLK. It replaces the fixed stimulus sequence of the PCS test environment with a programmable source. It emits bursts of preamble/SFD/payload frames separated by a programmable inter-packet gap, with selectable payload pattern, abort and optional error injection. The same generator feeds both simulation benches and on-chip loopback self-test.

## Interface
Parameters:
- PREAMBLE_LEN, 7: number of 0x55 preamble bytes before SFD (1..15).
- IPG_LEN, 12: idle cycles after each frame (minimum 1).
- LEN_W, 11: width of frame_len.
- CNT_W, 16: width of num_frames and frame_cnt.

Ports:
- GTX_CLK  in  1  transmit clock; the only clock.
- mr_main_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  finish the current frame and its IPG, then stop.
- frame_len  in  LEN_W  payload bytes per frame; latched at start.
- num_frames  in  CNT_W  frames per burst; latched at start.
- payload_mode  in  2  0 = incrementing, 1 = constant fill_byte, 2 = PRBS8, 3 = reserved (behaves as 0).
- fill_byte  in  8  constant payload byte; latched at start.
- err_en  in  1  enable error injection (ignored without macro).
- err_idx  in  LEN_W  payload byte index to corrupt (ignored without macro).
- TXD  out  8  GMII data, registered.
- TX_EN  out  1  GMII enable, registered.
- TX_ER  out  1  GMII error, registered.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- frame_cnt  out  CNT_W  frames fully sent in the current or last burst.

## Operation
- States: IDLE, PRE, SFD, PAY, IPG, DONE.
- IDLE: on start=1, latch inputs, clear frame_cnt, then go to PRE. If num_frames=0, go to DONE instead. A frame_len of 0 is treated as 1.
- PRE: TXD=0x55, TX_EN=1 for PREAMBLE_LEN cycles.
- SFD: TXD=0xD5, TX_EN=1 for 1 cycle.
- PAY: TX_EN=1 for frame_len cycles, with payload byte i (0-based) as follows:
  - mode 0: (frame index[7:0] + i) mod 256.
  - mode 1: fill_byte.
  - mode 2: LFSR x^8+x^6+x^5+x^4+1, seeded 0xFF at each SFD, outputs its current value, then advances once per byte.
- On the last PAY byte, frame_cnt increments.
- IPG: TX_EN=0, TX_ER=0, TXD=0x00 for IPG_LEN cycles. Then go to PRE if frame_cnt < num_frames and no abort is pending; otherwise go to DONE.
- DONE: done=1 and busy=0 for exactly 1 cycle, then go to IDLE.
- abort:
  - In PRE, SFD, PAY or IPG, abort sets a pending flag. The current frame and its IPG always complete; frames are never truncated.
  - In IDLE or DONE, abort is ignored.
- start while not in IDLE is ignored; the latched parameters are unaffected.
- Inputs are consumed only at start, so changing them mid-burst has no effect.
- Reset values: TXD=0x00, TX_EN=0, TX_ER=0, busy=0, done=0, frame_cnt=0, state IDLE, abort flag clear, LFSR=0xFF.

## Timing
- start at edge N: first 0x55 appears after edge N+1; busy=1 from that same cycle.
- One frame lasts PREAMBLE_LEN+1+frame_len cycles with TX_EN=1, followed by IPG_LEN cycles with TX_EN=0.
- TX_EN has no gaps inside a frame.
- done pulses in the cycle immediately after the final IPG cycle. busy is 0 in that cycle.
- With num_frames=0: done pulses at edge N+1 and TX_EN never rises.
- frame_cnt updates in the cycle after the last payload byte.
- Reset asserted mid-burst: all outputs take reset values after the next edge. No partial IPG or done pulse is produced.
- Back-to-back: start asserted in the IDLE cycle right after DONE is accepted.

## Configuration
- GMII_FRAME_GEN_ERR_INJECT_EN defined:
  - When err_en=1 and err_idx < frame_len, payload byte err_idx of every frame is driven as TXD=0x0F, TX_EN=1, TX_ER=1.
  - TX_ER=0 everywhere else.
- Macro undefined:
  - TX_ER is constant 0.
  - err_en and err_idx are unused.
  - No injection logic is synthesised.
- Port list is identical in both builds.

## Test plan
- Reset mid-PAY (defaults, frame_len=64, start, reset at cycle 20) -> next cycle TX_EN=0, TXD=0x00, busy=0, frame_cnt=0; a new start then gives 0x55 one cycle later.
- Single frame (frame_len=4, num_frames=1, mode 0) -> seven cycles of 0x55, then D5, 00, 01, 02, 03, then 12 cycles with TX_EN=0; done one cycle later; frame_cnt=1; TX_EN high for 12 cycles total.
- Burst (num_frames=3, frame_len=2, mode 0) -> payloads 00 01 / 01 02 / 02 03; exactly 12 idle cycles between frames; frame_cnt steps 1, 2, 3; a single done pulse.
- PRBS (mode 2, frame_len=3) -> payload FF, then the next two LFSR states; identical bytes in every frame.
- Abort in frame 2 of 5 -> frame 2 completes with its IPG, then done; frame_cnt=2; start while busy is ignored.
- Error injection with macro defined (err_en=1, err_idx=1, frame_len=3, mode 1, fill_byte=0xAA) -> payload AA, 0F with TX_ER=1, AA.
- Error injection without the macro -> TX_ER=0 throughout; num_frames=0 gives done at N+1 with no TX_EN.
